// File: rtl/output_buffer_1x1_ctrl_pkg.sv
// Shared geometry, address types and FSM state encoding for the 1x1-conv output buffer and its sequencer.
package output_buffer_1x1_ctrl_pkg;

    localparam int OUT_CHANNELS = 3;
    localparam int IN_WIDTH     = 5;
    localparam int IN_HEIGHT    = 5;
    localparam int PIXELS       = IN_WIDTH * IN_HEIGHT;
    localparam int DEPTH        = PIXELS * OUT_CHANNELS;
    localparam int WA_W         = $clog2(DEPTH);
    localparam int RA_W         = $clog2(PIXELS);
    localparam int DATA_W       = 8;

    typedef enum logic {FILL, DRAIN} state_t;

    typedef logic [WA_W-1:0] wa_t;
    typedef logic [RA_W-1:0] ra_t;

    // DEPTH and PIXELS are not powers of two, so wrap points are explicit compares.
    localparam wa_t WA_LAST = wa_t'(DEPTH - 1);
    localparam ra_t RA_LAST = ra_t'(PIXELS - 1);

endpackage

// File: rtl/output_buffer_1x1_ctrl_if.sv
// Handshake and RAM-address bundle between the sequencer and its PE array, buffer RAM and downstream consumer.
interface output_buffer_1x1_ctrl_if;
    import output_buffer_1x1_ctrl_pkg::*;

    logic in_valid;
    logic in_ready;
    logic wr_en;
    wa_t  wr_addr;
    logic rd_en;
    ra_t  rd_addr;
    logic out_valid;
    logic out_ready;
    logic frame_done;
    logic busy_drain;

    modport master (
        input  in_valid, out_ready,
        output in_ready, wr_en, wr_addr, rd_en, rd_addr, out_valid, frame_done, busy_drain
    );

    modport slave (
        output in_valid, out_ready,
        input  in_ready, wr_en, wr_addr, rd_en, rd_addr, out_valid, frame_done, busy_drain
    );

endinterface

// File: rtl/output_buffer_1x1.sv
// Frame RAM: scalar write port, pixel-vector read port; 1-cycle registered read.
// Read data register holds while rd_en is low, so a stalled consumer sees stable data.
module output_buffer_1x1
    import output_buffer_1x1_ctrl_pkg::*;
(
    input  logic                           clk,
    input  logic                           wr_en,
    input  wa_t                            wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           rd_en,
    input  ra_t                            rd_addr,
    output logic [OUT_CHANNELS*DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    wa_t               rd_base;

    assign rd_base = wa_t'(rd_addr) * wa_t'(OUT_CHANNELS);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            for (int c = 0; c < OUT_CHANNELS; c++) begin
                rd_data[c*DATA_W +: DATA_W] <= mem[rd_base + wa_t'(c)];
            end
        end
    end

endmodule

// File: rtl/output_buffer_1x1_ctrl.sv
// Fill/drain sequencer for the output buffer: one scalar write per accepted beat, then one vector read per slot.
// Read latency 1 cycle; upstream stalled during drain; downstream stall freezes reads with data held in the RAM.
module output_buffer_1x1_ctrl
    import output_buffer_1x1_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    output_buffer_1x1_ctrl_if.master bus
);

    state_t state;
    wa_t    wr_addr;
    ra_t    rd_addr;
    logic   all_issued;
    logic   out_valid;

    logic   wr_fire;
    logic   rd_fire;
    logic   last_accept;

    assign wr_fire     = bus.in_valid & (state == FILL);
    assign rd_fire     = (state == DRAIN) & ~all_issued & (~out_valid | bus.out_ready);
    assign last_accept = (state == DRAIN) & all_issued & out_valid & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            wr_addr    <= '0;
            rd_addr    <= '0;
            all_issued <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (wr_fire) begin
                        if (wr_addr == WA_LAST) begin
                            wr_addr    <= '0;
                            all_issued <= 1'b0;
                            state      <= DRAIN;
                        end else begin
                            wr_addr <= wr_addr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (rd_fire) begin
                        // rd_addr wraps after the last pixel; all_issued stops further reads.
                        if (rd_addr == RA_LAST) begin
                            rd_addr    <= '0;
                            all_issued <= 1'b1;
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                        out_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid <= 1'b0;
                    end
                    if (last_accept) begin
                        rd_addr    <= '0;
                        all_issued <= 1'b0;
                        out_valid  <= 1'b0;
                        state      <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.in_ready   = (state == FILL);
    assign bus.wr_en      = wr_fire;
    assign bus.wr_addr    = wr_addr;
    assign bus.rd_en      = rd_fire;
    assign bus.rd_addr    = rd_addr;
    assign bus.out_valid  = out_valid;
    assign bus.frame_done = last_accept;
    assign bus.busy_drain = (state == DRAIN);

endmodule
